// File: rtl/pic16_alu.sv
// ============================================================================
// pic16_alu : 8-bit PIC16-style ALU with the working register W.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module pic16_alu (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [4:0] CB,
  input  logic       WE,
  input  logic [2:0] B,
  input  logic [7:0] FI,
  output logic [7:0] FO,
  input  logic       CI,
  output logic       CO,
  output logic       DC,
  output logic       Z
);

  logic [7:0] w_q;
  logic [7:0] w_d;

  logic [8:0] w_add;
  logic [4:0] w_add_lo;
  logic [7:0] w_sub;
  logic [7:0] w_mask;

  assign w_add    = {1'b0, FI} + {1'b0, w_q};
  assign w_add_lo = {1'b0, FI[3:0]} + {1'b0, w_q[3:0]};
  assign w_sub    = FI - w_q;
  assign w_mask   = 8'h01 << B;

  always_comb begin
    FO = 8'h00;
    CO = 1'b0;
    DC = 1'b0;
    Z  = 1'b0;
    if (CB[4]) begin
      // Bit ops: Z reports the tested bit inverted, independent of FO.
      case (CB[3:2])
        2'b00:   FO = FI & ~w_mask;
        2'b01:   FO = FI | w_mask;
        default: FO = FI;
      endcase
      Z = ~|(FI & w_mask);
    end else begin
      case (CB[3:0])
        4'b0000: FO = w_q;
        4'b0001: FO = 8'h00;
        4'b0010: begin
          FO = w_sub;
          CO = (FI >= w_q);
          DC = (FI[3:0] >= w_q[3:0]);
        end
        4'b0011: FO = FI - 8'd1;
        4'b0100: FO = FI | w_q;
        4'b0101: FO = FI & w_q;
        4'b0110: FO = FI ^ w_q;
        4'b0111: begin
          FO = w_add[7:0];
          CO = w_add[8];
          DC = w_add_lo[4];
        end
        4'b1000: FO = FI;
        4'b1001: FO = ~FI;
        4'b1010: FO = FI + 8'd1;
        4'b1011: FO = FI - 8'd1;
        4'b1100: begin
          FO = {CI, FI[7:1]};
          CO = FI[0];
        end
        4'b1101: begin
          FO = {FI[6:0], CI};
          CO = FI[7];
        end
        4'b1110: FO = {FI[3:0], FI[7:4]};
        default: FO = FI + 8'd1;
      endcase
      Z = (FO == 8'h00);
    end
  end

  always_comb begin
    w_d = w_q;
    if (WE) w_d = FO;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) w_q <= 8'h00;
    else       w_q <= w_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_pic16_alu.sv
// Self-checking bench for pic16_alu: directed vectors plus randomized ops vs a model.
`default_nettype none

module tb_pic16_alu;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [4:0] CB;
  logic       WE;
  logic [2:0] B;
  logic [7:0] FI;
  logic [7:0] FO;
  logic       CI;
  logic       CO;
  logic       DC;
  logic       Z;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] model_w;

  pic16_alu dut (
    .CLK (CLK),
    .nRST(nRST),
    .CB  (CB),
    .WE  (WE),
    .B   (B),
    .FI  (FI),
    .FO  (FO),
    .CI  (CI),
    .CO  (CO),
    .DC  (DC),
    .Z   (Z)
  );

  always #5 CLK = ~CLK;

  // Reference: returns {FO, CO, DC, Z} computed with integer arithmetic.
  function automatic logic [10:0] model(input logic [4:0] cb, input logic [7:0] fi,
                                        input logic [2:0] b, input logic ci,
                                        input logic [7:0] w);
    int f = int'(fi);
    int wv = int'(w);
    int bi = int'(b);
    int r = 0;
    logic co = 1'b0;
    logic dc = 1'b0;
    logic z;
    logic [7:0] r8;
    if (cb[4]) begin
      r = f;
      if (cb[3:2] == 2'b00 && ((f >> bi) % 2) == 1) r = f - (1 << bi);
      if (cb[3:2] == 2'b01 && ((f >> bi) % 2) == 0) r = f + (1 << bi);
      z = (((f >> bi) % 2) == 0);
      r8 = 8'(r);
    end else begin
      case (int'(cb[3:0]))
        0:  r = wv;
        1:  r = 0;
        2:  begin r = f - wv; co = (f >= wv); dc = ((f % 16) >= (wv % 16)); end
        3:  r = f - 1;
        4:  r = f | wv;
        5:  r = f & wv;
        6:  r = f ^ wv;
        7:  begin r = f + wv; co = (r > 255); dc = ((f % 16) + (wv % 16)) > 15; end
        8:  r = f;
        9:  r = 255 - f;
        10: r = f + 1;
        11: r = f - 1;
        12: begin r = (ci ? 128 : 0) + f / 2; co = (f % 2) == 1; end
        13: begin r = (f * 2) % 256 + (ci ? 1 : 0); co = (f >= 128); end
        14: r = (f % 16) * 16 + f / 16;
        default: r = f + 1;
      endcase
      r8 = 8'(((r % 256) + 256) % 256);
      z = (r8 == 8'h00);
    end
    return {r8, co, dc, z};
  endfunction

  task automatic drive(input logic [4:0] cb, input logic [7:0] fi, input logic [2:0] b,
                       input logic ci, input logic we);
    @(negedge CLK);
    CB = cb; FI = fi; B = b; CI = ci; WE = we;
    #1;
  endtask

  task automatic load_w(input logic [7:0] val);
    drive(5'b01000, val, 3'd0, 1'b0, 1'b1);
    @(posedge CLK);
    #1 WE = 1'b0;
    model_w = val;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    drive(5'b01000, 8'h5A, 3'd0, 1'b0, 1'b1);
    @(posedge CLK);
    #1 nRST = 1'b1; WE = 1'b0;
    model_w = 8'h00;
    drive(5'b00000, 8'h5A, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if ({FO, Z} !== {8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_w: FO=%h Z=%b expected FO=00 Z=1", FO, Z);
    end
  endtask

  task automatic test_load_w;
    load_w(8'h3C);
    drive(5'b00000, 8'h00, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if (FO !== 8'h3C) begin
      n_fail++;
      $display("FAIL load_w: FO=%h expected 3C", FO);
    end
    drive(5'b01000, 8'hC3, 3'd0, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    drive(5'b00000, 8'hC3, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if (FO !== 8'h3C) begin
      n_fail++;
      $display("FAIL hold_w: FO=%h expected 3C", FO);
    end
  endtask

  task automatic test_add;
    load_w(8'hF8);
    drive(5'b00111, 8'h08, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if ({FO, CO, DC, Z} !== {8'h00, 3'b111}) begin
      n_fail++;
      $display("FAIL add_wrap: FO=%h CO=%b DC=%b Z=%b expected 00 1 1 1", FO, CO, DC, Z);
    end
    load_w(8'h01);
    drive(5'b00111, 8'h0E, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if ({FO, CO, DC, Z} !== {8'h0F, 3'b000}) begin
      n_fail++;
      $display("FAIL add_small: FO=%h CO=%b DC=%b Z=%b expected 0F 0 0 0", FO, CO, DC, Z);
    end
  endtask

  task automatic test_sub;
    load_w(8'h05);
    drive(5'b00010, 8'h03, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if ({FO, CO, DC, Z} !== {8'hFE, 3'b000}) begin
      n_fail++;
      $display("FAIL sub_borrow: FO=%h CO=%b DC=%b Z=%b expected FE 0 0 0", FO, CO, DC, Z);
    end
    drive(5'b00010, 8'h05, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if ({FO, CO, DC, Z} !== {8'h00, 3'b111}) begin
      n_fail++;
      $display("FAIL sub_equal: FO=%h CO=%b DC=%b Z=%b expected 00 1 1 1", FO, CO, DC, Z);
    end
  endtask

  task automatic test_rotate_swap;
    drive(5'b01100, 8'h81, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if ({FO, CO} !== {8'h40, 1'b1}) begin
      n_fail++;
      $display("FAIL rrf: FO=%h CO=%b expected 40 1", FO, CO);
    end
    drive(5'b01101, 8'h81, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if ({FO, CO} !== {8'h02, 1'b1}) begin
      n_fail++;
      $display("FAIL rlf: FO=%h CO=%b expected 02 1", FO, CO);
    end
    drive(5'b01110, 8'hA5, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if (FO !== 8'h5A) begin
      n_fail++;
      $display("FAIL swapf: FO=%h expected 5A", FO);
    end
  endtask

  task automatic test_inc_dec_wrap;
    drive(5'b01010, 8'hFF, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if ({FO, Z} !== {8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL incf_wrap: FO=%h Z=%b expected 00 1", FO, Z);
    end
    drive(5'b00011, 8'h00, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if ({FO, Z} !== {8'hFF, 1'b0}) begin
      n_fail++;
      $display("FAIL decf_wrap: FO=%h Z=%b expected FF 0", FO, Z);
    end
  endtask

  task automatic test_bits;
    drive(5'b10100, 8'h00, 3'd3, 1'b0, 1'b0);
    n_checks++;
    if (FO !== 8'h08) begin
      n_fail++;
      $display("FAIL bsf: FO=%h expected 08", FO);
    end
    drive(5'b10000, 8'hFF, 3'd7, 1'b0, 1'b0);
    n_checks++;
    if (FO !== 8'h7F) begin
      n_fail++;
      $display("FAIL bcf: FO=%h expected 7F", FO);
    end
    drive(5'b11000, 8'h08, 3'd3, 1'b0, 1'b0);
    n_checks++;
    if ({FO, Z} !== {8'h08, 1'b0}) begin
      n_fail++;
      $display("FAIL btfsc_set: FO=%h Z=%b expected 08 0", FO, Z);
    end
    drive(5'b11011, 8'h08, 3'd2, 1'b0, 1'b0);
    n_checks++;
    if ({FO, Z, CO, DC} !== {8'h08, 3'b100}) begin
      n_fail++;
      $display("FAIL btfss_clr: FO=%h Z=%b CO=%b DC=%b expected 08 1 0 0", FO, Z, CO, DC);
    end
  endtask

  task automatic test_random;
    logic [10:0] exp;
    logic [4:0]  cb;
    logic [7:0]  fi;
    logic [2:0]  b;
    logic        ci;
    logic        we;
    for (int i = 0; i < 400; i++) begin
      cb = 5'($urandom);
      fi = 8'($urandom);
      b  = 3'($urandom);
      ci = 1'($urandom);
      we = ($urandom_range(0, 3) == 0);
      drive(cb, fi, b, ci, we);
      exp = model(cb, fi, b, ci, model_w);
      n_checks++;
      if ({FO, CO, DC, Z} !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] cb=%b fi=%h b=%0d ci=%b w=%h: got FO=%h CO=%b DC=%b Z=%b expected FO=%h CO=%b DC=%b Z=%b",
                 i, cb, fi, b, ci, model_w, FO, CO, DC, Z, exp[10:3], exp[2], exp[1], exp[0]);
      end
      @(posedge CLK);
      if (we) model_w = exp[10:3];
    end
    WE = 1'b0;
    drive(5'b00000, 8'h00, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if (FO !== model_w) begin
      n_fail++;
      $display("FAIL random_final_w: FO=%h expected %h", FO, model_w);
    end
  endtask

  initial begin
    nRST = 1'b0; WE = 1'b0; CB = 5'd0; B = 3'd0; FI = 8'd0; CI = 1'b0;
    model_w = 8'h00;
    test_reset();
    test_load_w();
    test_add();
    test_sub();
    test_rotate_swap();
    test_inc_dec_wrap();
    test_bits();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
